// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_NIGHT  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_SET_G = 2'b10;
    localparam logic [1:0] MODE_SET_Y = 2'b11;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Board-side bundle of the traffic phase sequencer.
// Signal semantics: there is no valid/ready handshake here. mode and the
// raw keys are level inputs sampled every clk; lamps, active_grp, phase_cnt
// and tick are registered outputs; disp_val is combinational from mode and
// registered state; dbg_state mirrors the sequencer state register.
interface traffic_phase_ctrl_if
    import traffic_pkg::*;
#(
    parameter int NUM_GRP   = 2,
    parameter int CNT_WIDTH = 11
);
    logic [1:0]           mode;
    logic                 key_plus;
    logic                 key_sub;
    logic [NUM_GRP-1:0]   red;
    logic [NUM_GRP-1:0]   yellow;
    logic [NUM_GRP-1:0]   green;
    logic [2:0]           active_grp;
    logic [CNT_WIDTH-1:0] phase_cnt;
    logic [CNT_WIDTH-1:0] disp_val;
    logic                 tick;
    state_e               dbg_state;

    modport master (
        output mode, key_plus, key_sub,
        input  red, yellow, green, active_grp, phase_cnt, disp_val, tick, dbg_state
    );

    modport slave (
        input  mode, key_plus, key_sub,
        output red, yellow, green, active_grp, phase_cnt, disp_val, tick, dbg_state
    );
endinterface

// File: rtl/key_edge.sv
// Two-flop key synchroniser with a falling-edge pulse output.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw key into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[0], key};
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= sync_d;
    end

    // Previous high and current low marks a press.
    assign pulse = sync_q[1] & ~sync_q[0];
endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic-light sequencer with all-red clearance, adjustable
// green/yellow durations and a flashing-yellow night mode.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_GRP    = 2,
    parameter int CNT_WIDTH  = 11,
    parameter int TICK_DIV   = 12000000,
    parameter int GREEN_DEF  = 8,
    parameter int YELLOW_DEF = 6,
    parameter int ALLRED_DUR = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    traffic_phase_ctrl_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0]           LAST_GRP   = 3'(NUM_GRP - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] ALLRED_LEN = CNT_WIDTH'((ALLRED_DUR == 0) ? 1 : ALLRED_DUR);

    // A zero duration would stall the countdown, so it runs as one second.
    function automatic logic [CNT_WIDTH-1:0] min1(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

    // Saturating +1/-1 on a duration setting; the floor is 1.
    function automatic logic [CNT_WIDTH-1:0] adjust(input logic [CNT_WIDTH-1:0] v,
                                                    input logic up, input logic dn);
        if (up && v != CNT_MAX) return v + CNT_ONE;
        if (dn && v > CNT_ONE)  return v - CNT_ONE;
        return v;
    endfunction

    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick_q, tick_d;
    state_e               state_q, state_d;
    logic [2:0]           grp_q, grp_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 blink_q, blink_d;
    logic [CNT_WIDTH-1:0] green_set_q, green_set_d;
    logic [CNT_WIDTH-1:0] yellow_set_q, yellow_set_d;
    logic [NUM_GRP-1:0]   red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic                 plus_pulse, sub_pulse;
    logic [2:0]           next_grp;

    key_edge u_key_plus (.clk(clk), .rst_n(rst_n), .key(bus.key_plus), .pulse(plus_pulse));
    key_edge u_key_sub  (.clk(clk), .rst_n(rst_n), .key(bus.key_sub),  .pulse(sub_pulse));

    // Free-running prescaler; tick marks the cycle right after the wrap.
    always_comb begin
        tick_d  = (presc_q == PRESC_LAST);
        presc_d = tick_d ? '0 : presc_q + PW'(1);
    end

    // Sequencer next state: night override, night exit via clearance, run countdown.
    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        cnt_d    = cnt_q;
        blink_d  = blink_q;
        next_grp = (grp_q == LAST_GRP) ? 3'd0 : grp_q + 3'd1;
        if (bus.mode == MODE_NIGHT) begin
            if (state_q != ST_NIGHT) begin
                state_d = ST_NIGHT;
                cnt_d   = '0;
                blink_d = 1'b1;
            end else if (tick_q) begin
                blink_d = ~blink_q;
            end
        end else if (state_q == ST_NIGHT) begin
            state_d = ST_ALLRED;
            grp_d   = LAST_GRP;
            cnt_d   = ALLRED_LEN;
            blink_d = 1'b0;
        end else if (bus.mode == MODE_RUN && tick_q) begin
            if (cnt_q > CNT_ONE) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                case (state_q)
                    ST_GREEN: begin
                        state_d = ST_YELLOW;
                        cnt_d   = min1(yellow_set_q);
                    end
                    ST_YELLOW: begin
                        if (ALLRED_DUR == 0) begin
                            state_d = ST_GREEN;
                            grp_d   = next_grp;
                            cnt_d   = min1(green_set_q);
                        end else begin
                            state_d = ST_ALLRED;
                            cnt_d   = ALLRED_LEN;
                        end
                    end
                    ST_ALLRED: begin
                        state_d = ST_GREEN;
                        grp_d   = next_grp;
                        cnt_d   = min1(green_set_q);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Lamps are decoded from the next state so they register with it.
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        if (state_d == ST_NIGHT) begin
            red_d    = '0;
            yellow_d = {NUM_GRP{blink_d}};
        end else begin
            for (int i = 0; i < NUM_GRP; i++) begin
                if (grp_d == 3'(i) && state_d == ST_GREEN) begin
                    red_d[i]   = 1'b0;
                    green_d[i] = 1'b1;
                end
                if (grp_d == 3'(i) && state_d == ST_YELLOW) begin
                    red_d[i]    = 1'b0;
                    yellow_d[i] = 1'b1;
                end
            end
        end
    end

    // Duration settings move only in their own set mode.
    always_comb begin
        green_set_d  = green_set_q;
        yellow_set_d = yellow_set_q;
        if (bus.mode == MODE_SET_G)
            green_set_d = adjust(green_set_q, plus_pulse & ~sub_pulse, sub_pulse & ~plus_pulse);
        if (bus.mode == MODE_SET_Y)
            yellow_set_d = adjust(yellow_set_q, plus_pulse & ~sub_pulse, sub_pulse & ~plus_pulse);
    end

    // All sequencer, lamp, setting and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            tick_q       <= 1'b0;
            state_q      <= ST_ALLRED;
            grp_q        <= LAST_GRP;
            cnt_q        <= ALLRED_LEN;
            blink_q      <= 1'b0;
            green_set_q  <= CNT_WIDTH'(GREEN_DEF);
            yellow_set_q <= CNT_WIDTH'(YELLOW_DEF);
            red_q        <= '1;
            yellow_q     <= '0;
            green_q      <= '0;
        end else begin
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            grp_q        <= grp_d;
            cnt_q        <= cnt_d;
            blink_q      <= blink_d;
            green_set_q  <= green_set_d;
            yellow_set_q <= yellow_set_d;
            red_q        <= red_d;
            yellow_q     <= yellow_d;
            green_q      <= green_d;
        end
    end

    assign bus.red        = red_q;
    assign bus.yellow     = yellow_q;
    assign bus.green      = green_q;
    assign bus.active_grp = grp_q;
    assign bus.phase_cnt  = cnt_q;
    assign bus.tick       = tick_q;
    assign bus.dbg_state  = state_q;
    assign bus.disp_val   = (bus.mode == MODE_SET_G) ? green_set_q  :
                            (bus.mode == MODE_SET_Y) ? yellow_set_q : cnt_q;
endmodule
